i2s_sample_sched: RTL

- Playback controller between the sample source (valid/ready stream, already in the audio clock domain) and the I2S serializer.
- Buffers stereo samples in a FIFO and primes it before starting.
- Presents one sample per serializer frame request, substitutes silence on underrun, and drains cleanly on stop.
- Exposes state, fill level and an underrun counter for status registers.

---
 rtl/i2s_sample_sched.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/i2s_sample_sched.sv
// i2s_sample_sched: playback scheduler between a valid/ready sample stream and
// an I2S serializer. Samples are buffered in a FIFO with a single staging
// register in front of the serializer. The FIFO must be primed before playback
// starts. Silence is presented on underrun, and the buffer drains cleanly on stop.
module i2s_sample_sched #(
    parameter int          DEPTH       = 16,
    parameter int          PRIME_LEVEL = 4,
    parameter logic [31:0] SILENCE     = 32'h0000_0000
) (
    input  logic                         aud_clk_i,
    input  logic                         aud_rst_i,
    input  logic                         enable_i,
    input  logic [31:0]                  s_data_i,
    input  logic                         s_valid_i,
    output logic                         s_ready_o,
    output logic [31:0]                  audio_data_o,
    input  logic                         audio_data_ready_i,
    output logic [1:0]                   state_o,
    output logic [$clog2(DEPTH+2)-1:0]   level_o,
    output logic [15:0]                  underrun_cnt_o,
    input  logic                         clear_i
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 2);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PRIME = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(DEPTH);
    localparam logic [LW-1:0] PRIME_LVL = LW'(PRIME_LEVEL);

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic [31:0]   r_mem [DEPTH];
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic [31:0]   r_staged;
    logic          r_staged_valid;
    logic [15:0]   r_underrun_cnt;

    logic [AW:0]   w_count;
    logic          w_empty;
    logic          w_full;
    logic          w_ready;
    logic          w_push;
    logic          w_pop;
    logic          w_active;
    logic          w_consume;
    logic          w_underrun;
    logic [LW-1:0] w_level;

    // The extra pointer bit separates full from empty when the index bits match.
    assign w_count    = r_wr_ptr - r_rd_ptr;
    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_full     = (w_count == FULL_CNT);
    assign w_ready    = ((r_state == ST_PRIME) || (r_state == ST_RUN)) && !w_full;
    assign w_push     = s_valid_i && w_ready;
    assign w_pop      = !r_staged_valid && !w_empty && (r_state != ST_IDLE);
    assign w_active   = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign w_consume  = audio_data_ready_i && w_active && r_staged_valid;
    assign w_underrun = audio_data_ready_i && (r_state == ST_RUN) && !r_staged_valid;
    assign w_level    = LW'(w_count) + LW'(r_staged_valid);

    // Outputs are built only from registers, so the serializer never sees a combinational path from inputs.
    assign s_ready_o      = w_ready;
    assign audio_data_o   = (w_active && r_staged_valid) ? r_staged : SILENCE;
    assign state_o        = r_state;
    assign level_o        = w_level;
    assign underrun_cnt_o = r_underrun_cnt;

    // Next-state selection for the playback FSM.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (enable_i) begin
                    w_state_nxt = ST_PRIME;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_PRIME: begin
                if (!enable_i) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_level >= PRIME_LVL) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_PRIME;
                end
            end
            ST_RUN: begin
                if (!enable_i) begin
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_DRAIN: begin
                // Resuming takes priority over finishing the drain.
                if (enable_i) begin
                    w_state_nxt = ST_RUN;
                end else if (w_empty && !r_staged_valid) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge aud_clk_i or posedge aud_rst_i) begin
        if (aud_rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FIFO pointers; IDLE holds the FIFO flushed.
    always_ff @(posedge aud_clk_i or posedge aud_rst_i) begin
        if (aud_rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (r_state == ST_IDLE) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // FIFO storage; contents are qualified by the pointers, so no reset is needed.
    always_ff @(posedge aud_clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= s_data_i;
        end
    end

    // Staging register: refills from the FIFO head whenever it is empty.
    always_ff @(posedge aud_clk_i or posedge aud_rst_i) begin
        if (aud_rst_i) begin
            r_staged       <= SILENCE;
            r_staged_valid <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            r_staged_valid <= 1'b0;
        end else if (w_pop) begin
            r_staged       <= r_mem[r_rd_ptr[AW-1:0]];
            r_staged_valid <= 1'b1;
        end else if (w_consume) begin
            r_staged_valid <= 1'b0;
        end else begin
            r_staged_valid <= r_staged_valid;
        end
    end

    // Saturating underrun counter; a clear coinciding with an underrun leaves 1.
    always_ff @(posedge aud_clk_i or posedge aud_rst_i) begin
        if (aud_rst_i) begin
            r_underrun_cnt <= 16'h0000;
        end else if (clear_i) begin
            r_underrun_cnt <= w_underrun ? 16'h0001 : 16'h0000;
        end else if (w_underrun && (r_underrun_cnt != 16'hFFFF)) begin
            r_underrun_cnt <= r_underrun_cnt + 16'h0001;
        end else begin
            r_underrun_cnt <= r_underrun_cnt;
        end
    end

endmodule
